riscv_exc_controller: RTL and testbench

Exception and interrupt arbiter that sits directly upstream of the control and status registers. It collects synchronous exception flags from the ID/EX stages and the 32 level-sensitive interrupt lines, gated by the mstatus IE bit. It issues a single request/acknowledge handshake to the core controller, and produces the 6-bit cause value and one-cycle save strobe that the CSR block stores into mcause.

---
 rtl/riscv_exc_controller.sv | 59 +++++
 tb/tb_riscv_exc_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/riscv_exc_controller.sv
// riscv_exc_controller: prioritises sync exceptions and interrupts into one request/ack handshake and mcause value
module riscv_exc_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irq_i,
  input  logic        irq_enable_i,
  input  logic        lsu_err_i,
  input  logic        illegal_insn_i,
  input  logic        ebrk_insn_i,
  input  logic        ecall_insn_i,
  output logic        req_o,
  input  logic        ack_i,
  output logic [5:0]  trap_cause_o,
  output logic        save_cause_o,
  output logic        is_irq_o
);
  typedef enum logic [1:0] {IDLE, PENDING, SAVE} state_t;
  state_t state_q, state_d;
  logic [5:0] cause_q, cause_d, cand;
  logic [4:0] irq_id;
  logic sync_v, irq_v, cand_v;
  always_comb begin
    irq_id = 5'd0;
    for (int i = 31; i >= 0; i--) irq_id = irq_i[i] ? 5'(i) : irq_id;
  end
  assign sync_v = lsu_err_i | illegal_insn_i | ebrk_insn_i | ecall_insn_i;
  assign irq_v  = irq_enable_i & |irq_i;
  assign cand_v = sync_v | irq_v;
  assign cand   = lsu_err_i      ? 6'h05 :
                  illegal_insn_i ? 6'h02 :
                  ebrk_insn_i    ? 6'h03 :
                  ecall_insn_i   ? 6'h0B : {1'b1, irq_id};
  // a pending interrupt tracks the current winner and withdraws when nothing is left; sync causes stay frozen
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (state_q == IDLE && cand_v) begin
      state_d = PENDING;
      cause_d = cand;
    end else if (state_q == PENDING) begin
      if (ack_i) state_d = SAVE;
      else if (cause_q[5] && cand_v) cause_d = cand;
      else if (cause_q[5]) state_d = IDLE;
    end else if (state_q == SAVE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= 6'h00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end
  assign req_o        = state_q == PENDING;
  assign save_cause_o = state_q == SAVE;
  assign is_irq_o     = req_o & cause_q[5];
  assign trap_cause_o = cause_q;
endmodule

// File: tb/tb_riscv_exc_controller.sv
// tb_riscv_exc_controller: table-driven vectors checked through an expected-output queue
module tb_riscv_exc_controller;
  logic clk = 0, rst = 1;
  logic [31:0] irq_i = 0;
  logic irq_enable_i = 0, lsu_err_i = 0, illegal_insn_i = 0, ebrk_insn_i = 0, ecall_insn_i = 0, ack_i = 0;
  logic req_o, save_cause_o, is_irq_o;
  logic [5:0] trap_cause_o;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic        rst;
    logic [31:0] irq;
    logic        ie;
    logic [3:0]  exc;
    logic        ack;
    logic        req;
    logic [5:0]  cause;
    logic        save;
    logic        isirq;
  } vec_t;
  typedef struct {
    logic       req;
    logic [5:0] cause;
    logic       save;
    logic       isirq;
    int         idx;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  riscv_exc_controller dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_enable_i(irq_enable_i),
    .lsu_err_i(lsu_err_i), .illegal_insn_i(illegal_insn_i), .ebrk_insn_i(ebrk_insn_i),
    .ecall_insn_i(ecall_insn_i), .req_o(req_o), .ack_i(ack_i), .trap_cause_o(trap_cause_o),
    .save_cause_o(save_cause_o), .is_irq_o(is_irq_o)
  );
  always #5 clk = ~clk;
  // exc bits: {lsu_err, illegal, ebreak, ecall}; expected outputs are those seen after the edge sampling the inputs
  task automatic add(input logic r, input logic [31:0] irq, input logic ie, input logic [3:0] exc,
                     input logic ack, input logic req, input logic [5:0] cause, input logic save, input logic isirq);
    tbl.push_back('{r, irq, ie, exc, ack, req, cause, save, isirq});
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] irq, input logic ie, input logic [3:0] exc, input logic ack);
    rst = r; irq_i = irq; irq_enable_i = ie; ack_i = ack;
    {lsu_err_i, illegal_insn_i, ebrk_insn_i, ecall_insn_i} = exc;
  endtask
  initial begin
    exp_t e;
    bit hit;
    add(1, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    add(1, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h00, 0, 0);
    add(0, 0, 0, 8, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h05, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h05, 0, 0);
    add(0, 32'h90, 1, 0, 0, 1, 6'h24, 0, 1);
    add(0, 32'h90, 1, 4, 0, 1, 6'h02, 0, 0);
    add(0, 32'h90, 1, 0, 1, 0, 6'h02, 1, 0);
    add(0, 0, 1, 0, 0, 0, 6'h02, 0, 0);
    add(0, 32'h8, 1, 0, 0, 1, 6'h23, 0, 1);
    add(0, 0, 1, 0, 0, 0, 6'h23, 0, 0);
    add(0, 0, 1, 0, 0, 0, 6'h23, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 6'h23, 0, 0);
    add(0, 32'hFFFF_FFFF, 0, 1, 0, 1, 6'h0B, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h0B, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h0B, 0, 0);
    add(0, 32'h8000_0001, 1, 0, 0, 1, 6'h20, 0, 1);
    add(0, 32'h8000_0000, 1, 0, 0, 1, 6'h3F, 0, 1);
    add(0, 32'h8000_0000, 1, 0, 1, 0, 6'h3F, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h3F, 0, 0);
    add(0, 32'h2, 1, 0, 0, 1, 6'h21, 0, 1);
    add(0, 32'h2, 1, 2, 1, 0, 6'h21, 1, 0);
    add(0, 0, 0, 2, 0, 0, 6'h21, 0, 0);
    add(0, 0, 0, 2, 0, 1, 6'h03, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h03, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h03, 0, 0);
    add(0, 32'hFF, 1, 4'hF, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 4, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h05, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h05, 0, 0);
    add(0, 0, 0, 7, 0, 1, 6'h02, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h02, 1, 0);
    add(0, 0, 0, 3, 0, 0, 6'h02, 0, 0);
    add(0, 0, 0, 3, 0, 1, 6'h03, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h03, 1, 0);
    add(0, 0, 0, 0, 0, 0, 6'h03, 0, 0);
    add(0, 0, 0, 8, 0, 1, 6'h05, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6'h05, 1, 0);
    add(1, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    add(0, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    add(0, 32'h1, 1, 0, 0, 1, 6'h20, 0, 1);
    add(1, 32'h1, 1, 0, 0, 0, 6'h00, 0, 0);
    add(0, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].irq, tbl[i].ie, tbl[i].exc, tbl[i].ack);
      sb.push_back('{tbl[i].req, tbl[i].cause, tbl[i].save, tbl[i].isirq, i});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d req", e.idx), req_o, e.req);
      check($sformatf("v%0d cause", e.idx), trap_cause_o, e.cause);
      check($sformatf("v%0d save", e.idx), save_cause_o, e.save);
      check($sformatf("v%0d is_irq", e.idx), is_irq_o, e.isirq);
    end
    // handshake driven by watching the DUT, each wait bounded
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    hit = 0;
    for (int c = 0; c < 5 && !hit; c++) begin
      if (req_o) hit = 1; else @(negedge clk);
    end
    check("hs req seen", hit, 1);
    check("hs cause", trap_cause_o, 6'h0B);
    ack_i = 1;
    @(negedge clk);
    ack_i = 0;
    hit = 0;
    for (int c = 0; c < 5 && !hit; c++) begin
      if (save_cause_o) hit = 1; else @(negedge clk);
    end
    check("hs save seen", hit, 1);
    check("hs save cause", trap_cause_o, 6'h0B);
    @(negedge clk);
    check("hs save one cycle", save_cause_o, 0);
    check("hs idle req", req_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
